// File: rtl/bus_arb_pkg.sv
// Shared constants for the two-master system bus arbiter: FSM state encoding
// and bus widths.
package bus_arb_pkg;

  localparam int BUS_AW = 22;
  localparam int BUS_DW = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  // One-hot grant vector (bit0 = m0, bit1 = m1) for a given state.
  function automatic logic [1:0] state_to_gnt(input logic [1:0] st);
    logic [1:0] g;
    g = 2'b00;
    if (st == ST_GNT0) g = 2'b01;
    if (st == ST_GNT1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/bus_arb_tmo.sv
// Hung-slave watchdog: counts granted cycles without bus_ack and flags expiry
// when the count reaches TIMEOUT_CYCLES-1. Only built with BUS_ARB_TIMEOUT_EN.
module bus_arb_tmo #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ack,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Every grant is preceded by an IDLE cycle, so clearing while not running
  // is the same as clearing on entry to a grant state.
  always_comb begin
    cnt_d = '0;
    if (run && !ack) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = run && !ack && (cnt_q == LIMIT);

endmodule

// File: rtl/bus_arb.sv
// Round-robin arbiter sharing the system bus between master 0 (CPU) and
// master 1. Optional hung-slave timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [BUS_AW-1:0] m0_addr,
  input  logic [BUS_DW-1:0] m0_dout,
  output logic [BUS_DW-1:0] m0_din,
  output logic              m0_ack,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [BUS_AW-1:0] m1_addr,
  input  logic [BUS_DW-1:0] m1_dout,
  output logic [BUS_DW-1:0] m1_din,
  output logic              m1_ack,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [BUS_DW-1:0] bus_dout,
  input  logic [BUS_DW-1:0] bus_din,
  input  logic              bus_ack,
  output logic [1:0]        gnt,
  output logic              tmo_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_arb: TIMEOUT_CYCLES must be in 2..65535");
  end

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;

  logic              gnt0, gnt1;
  logic              sel_stb, sel_we;
  logic [BUS_AW-1:0] sel_addr;
  logic [BUS_DW-1:0] sel_dout;
  logic              tmo_expire;
  logic              tmo_hit;
  logic              done;
  logic              xfer_end;
  logic [BUS_DW-1:0] rd_data;

  assign gnt  = state_to_gnt(state_q);
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_dout = '0;
    if (gnt0) begin
      sel_stb  = m0_stb;
      sel_we   = m0_we;
      sel_addr = m0_addr;
      sel_dout = m0_dout;
    end else if (gnt1) begin
      sel_stb  = m1_stb;
      sel_we   = m1_we;
      sel_addr = m1_addr;
      sel_dout = m1_dout;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic tmo_err_q;

  bus_arb_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .run    (gnt0 | gnt1),
    .ack    (bus_ack),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst)          tmo_err_q <= 1'b0;
    else if (tmo_hit) tmo_err_q <= 1'b1;
  end

  assign tmo_err = tmo_err_q;
`else
  assign tmo_expire = 1'b0;
  assign tmo_err    = 1'b0;
`endif

  // A master that dropped its strobe early gets neither a completion nor a
  // timeout ack; the grant is simply released.
  assign done     = sel_stb & bus_ack;
  assign tmo_hit  = sel_stb & tmo_expire;
  assign xfer_end = done | tmo_hit;
  assign rd_data  = done ? bus_din : '0;

  assign bus_stb  = sel_stb & ~tmo_hit;
  assign bus_we   = sel_we;
  assign bus_addr = sel_addr;
  assign bus_dout = sel_dout;

  assign m0_ack = gnt0 & xfer_end;
  assign m1_ack = gnt1 & xfer_end;
  assign m0_din = gnt0 ? rd_data : '0;
  assign m1_din = gnt1 ? rd_data : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_stb && m1_stb) state_d = last_q ? ST_GNT0 : ST_GNT1;
        else if (m0_stb)      state_d = ST_GNT0;
        else if (m1_stb)      state_d = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        if (!sel_stb) begin
          state_d = ST_IDLE;
        end else if (xfer_end) begin
          state_d = ST_IDLE;
          last_d  = (state_q == ST_GNT1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: vector table, directed corner cases and a
// randomized run against a transaction-level reference model.
module tb_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_stb, m0_we, m0_ack;
  logic [21:0] m0_addr;
  logic [31:0] m0_dout, m0_din;
  logic        m1_stb, m1_we, m1_ack;
  logic [21:0] m1_addr;
  logic [31:0] m1_dout, m1_din;
  logic        bus_stb, bus_we, bus_ack;
  logic [21:0] bus_addr;
  logic [31:0] bus_dout, bus_din;
  logic [1:0]  gnt;
  logic        tmo_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arb #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_din(m0_din), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_din(m1_din), .m1_ack(m1_ack),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack),
    .gnt(gnt), .tmo_err(tmo_err)
  );

  typedef struct {
    logic        s0, s1, ack;
    logic [31:0] din;
    logic [31:0] e_gnt, e_stb, e_we, e_addr, e_a0, e_a1, e_d0, e_d1;
  } vec_t;

  localparam logic [21:0] A0 = 22'h0000AA;
  localparam logic [21:0] A1 = 22'h155555;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_stb = 0; m0_we = 0; m0_addr = '0; m0_dout = '0;
    m1_stb = 0; m1_we = 0; m1_addr = '0; m1_dout = '0;
    bus_ack = 0; bus_din = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".gnt"},     32'(gnt), 0);
    check({tag, ".bus_stb"}, 32'(bus_stb), 0);
    check({tag, ".bus_we"},  32'(bus_we), 0);
    check({tag, ".bus_adr"}, 32'(bus_addr), 0);
    check({tag, ".bus_do"},  bus_dout, 0);
    check({tag, ".m0_ack"},  32'(m0_ack), 0);
    check({tag, ".m1_ack"},  32'(m1_ack), 0);
    check({tag, ".m0_din"},  m0_din, 0);
    check({tag, ".m1_din"},  m1_din, 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  function automatic vec_t mk(input logic s0, s1, ack, input logic [31:0] din, e_gnt,
                              e_d0, e_d1);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.ack = ack; v.din = din;
    v.e_gnt  = e_gnt;
    v.e_stb  = (e_gnt != 0) ? 1 : 0;
    v.e_we   = (e_gnt == 2) ? 1 : 0;
    v.e_addr = (e_gnt == 1) ? 32'(A0) : (e_gnt == 2) ? 32'(A1) : 0;
    v.e_a0   = (e_gnt == 1 && ack) ? 1 : 0;
    v.e_a1   = (e_gnt == 2 && ack) ? 1 : 0;
    v.e_d0   = e_d0;
    v.e_d1   = e_d1;
    return v;
  endfunction

  // Transaction-level reference model state for the random phase.
  int          owner;
  int          last;
  bit          req[2];
  logic        we_r[2];
  logic [21:0] addr_r[2];
  logic [31:0] dat_r[2];

  initial begin
    vec_t tbl[8];
    int   stall;

    // Reset state
    rst = 1;
    clear_inputs();
    do_reset();
    check_idle("reset");
    check("reset.tmo_err", 32'(tmo_err), 0);

    // Contention from reset: m0, m1, m0, m1 with one IDLE cycle between grants
    tbl[0] = mk(1, 1, 0, 32'h0,        0, 0, 0);
    tbl[1] = mk(1, 1, 1, 32'h11111111, 1, 32'h11111111, 0);
    tbl[2] = mk(1, 1, 1, 32'hDEAD0000, 0, 0, 0);
    tbl[3] = mk(1, 1, 1, 32'h22222222, 2, 0, 32'h22222222);
    tbl[4] = mk(1, 1, 0, 32'h0,        0, 0, 0);
    tbl[5] = mk(1, 1, 1, 32'h33333333, 1, 32'h33333333, 0);
    tbl[6] = mk(1, 1, 0, 32'h0,        0, 0, 0);
    tbl[7] = mk(1, 1, 1, 32'h44444444, 2, 0, 32'h44444444);
    m0_addr = A0; m0_we = 0; m0_dout = 32'h0A0A0A0A;
    m1_addr = A1; m1_we = 1; m1_dout = 32'h1B1B1B1B;
    foreach (tbl[i]) begin
      m0_stb = tbl[i].s0; m1_stb = tbl[i].s1;
      bus_ack = tbl[i].ack; bus_din = tbl[i].din;
      #1;
      check($sformatf("tbl%0d.gnt", i),    32'(gnt),      tbl[i].e_gnt);
      check($sformatf("tbl%0d.stb", i),    32'(bus_stb),  tbl[i].e_stb);
      check($sformatf("tbl%0d.we", i),     32'(bus_we),   tbl[i].e_we);
      check($sformatf("tbl%0d.addr", i),   32'(bus_addr), tbl[i].e_addr);
      check($sformatf("tbl%0d.m0_ack", i), 32'(m0_ack),   tbl[i].e_a0);
      check($sformatf("tbl%0d.m1_ack", i), 32'(m1_ack),   tbl[i].e_a1);
      check($sformatf("tbl%0d.m0_din", i), m0_din,        tbl[i].e_d0);
      check($sformatf("tbl%0d.m1_din", i), m1_din,        tbl[i].e_d1);
      tick();
    end
    clear_inputs();
    #1;
    check_idle("tbl_end");
    tick();

    // Write isolation: m1 writes alone, m0 sees nothing
    m1_stb = 1; m1_we = 1; m1_addr = 22'h3FFFC0; m1_dout = 32'h12345678;
    #1;
    check("wr.idle_gnt", 32'(gnt), 0);
    tick();
    check("wr.gnt", 32'(gnt), 2);
    check("wr.bus_we", 32'(bus_we), 1);
    check("wr.bus_dout", bus_dout, 32'h12345678);
    check("wr.bus_addr", 32'(bus_addr), 32'h3FFFC0);
    check("wr.m0_din", m0_din, 0);
    tick();
    bus_ack = 1; bus_din = 32'hCAFEF00D;
    #1;
    check("wr.m1_ack", 32'(m1_ack), 1);
    check("wr.m0_ack", 32'(m0_ack), 0);
    check("wr.m0_din_ack", m0_din, 0);
    tick();
    clear_inputs();

    // Single master read with a 3-cycle slave
    m0_stb = 1; m0_we = 0; m0_addr = 22'h000100; m0_dout = 32'h0;
    #1;
    check("rd.idle_gnt", 32'(gnt), 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 3) begin bus_ack = 1; bus_din = 32'hDEADBEEF; end
      #1;
      check($sformatf("rd.c%0d.gnt", c), 32'(gnt), 1);
      check($sformatf("rd.c%0d.stb", c), 32'(bus_stb), 1);
      check($sformatf("rd.c%0d.m0_ack", c), 32'(m0_ack), (c == 3) ? 1 : 0);
      check($sformatf("rd.c%0d.m1_ack", c), 32'(m1_ack), 0);
    end
    check("rd.m0_din", m0_din, 32'hDEADBEEF);
    check("rd.addr", 32'(bus_addr), 32'h100);
    tick();
    clear_inputs();
    #1;
    check_idle("rd_end");

    // Reset mid-transaction: last is m0 here, so only reset makes m0 win next
    m1_stb = 1; m1_addr = 22'h000321;
    tick();
    check("rst_mid.gnt", 32'(gnt), 2);
    rst = 1;
    tick();
    rst = 0; m1_stb = 0;
    #1;
    check_idle("rst_mid");
    m0_stb = 1; m1_stb = 1; m0_addr = A0; m1_addr = A1;
    tick();
    check("rst_mid.first_gnt", 32'(gnt), 1);
    bus_ack = 1; bus_din = 32'h5;
    #1;
    check("rst_mid.m0_ack", 32'(m0_ack), 1);
    tick();
    clear_inputs();

    // Strobe dropped without ack: no ack, last stays m0, so m1 wins next
    tick();
    m1_stb = 1;
    tick();
    check("drop.gnt", 32'(gnt), 2);
    m1_stb = 0;
    #1;
    check("drop.bus_stb", 32'(bus_stb), 0);
    check("drop.m1_ack", 32'(m1_ack), 0);
    tick();
    check("drop.idle", 32'(gnt), 0);
    m0_stb = 1; m1_stb = 1;
    tick();
    check("drop.next_gnt", 32'(gnt), 2);
    bus_ack = 1;
    tick();
    clear_inputs();

`ifndef BUS_ARB_TIMEOUT_EN
    // Without the watchdog a silent slave holds the grant indefinitely
    m0_stb = 1;
    for (int c = 0; c < 20; c++) tick();
    check("hang.gnt", 32'(gnt), 1);
    check("hang.m0_ack", 32'(m0_ack), 0);
    check("hang.tmo_err", 32'(tmo_err), 0);
    bus_ack = 1;
    tick();
    clear_inputs();
`endif

    // Randomized traffic against the reference model
    do_reset();
    owner = -1; last = 1; stall = 0;
    req[0] = 0; req[1] = 0;
    for (int c = 0; c < 400; c++) begin
      logic        ack;
      logic [31:0] din;
      logic [31:0] e_gnt, e_stb, e_we, e_addr, e_dout, e_a0, e_a1, e_d0, e_d1;
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]    = 1;
          we_r[i]   = 1'($urandom);
          addr_r[i] = 22'($urandom);
          dat_r[i]  = $urandom;
        end
      end
      m0_stb  = req[0];
      m0_we   = req[0] ? we_r[0] : 1'($urandom);
      m0_addr = req[0] ? addr_r[0] : 22'($urandom);
      m0_dout = req[0] ? dat_r[0] : $urandom;
      m1_stb  = req[1];
      m1_we   = req[1] ? we_r[1] : 1'($urandom);
      m1_addr = req[1] ? addr_r[1] : 22'($urandom);
      m1_dout = req[1] ? dat_r[1] : $urandom;
      if (owner >= 0) ack = ($urandom_range(0, 1) == 1) || (stall >= 3);
      else            ack = ($urandom_range(0, 3) == 0);
      din = $urandom;
      bus_ack = ack; bus_din = din;
      #1;
      e_gnt = 0; e_stb = 0; e_we = 0; e_addr = 0; e_dout = 0;
      e_a0 = 0; e_a1 = 0; e_d0 = 0; e_d1 = 0;
      if (owner >= 0) begin
        e_gnt  = (owner == 0) ? 1 : 2;
        e_stb  = 1;
        e_we   = 32'(we_r[owner]);
        e_addr = 32'(addr_r[owner]);
        e_dout = dat_r[owner];
        if (owner == 0) begin e_a0 = 32'(ack); e_d0 = ack ? din : 0; end
        else            begin e_a1 = 32'(ack); e_d1 = ack ? din : 0; end
      end
      check("rnd.gnt",    32'(gnt),      e_gnt);
      check("rnd.stb",    32'(bus_stb),  e_stb);
      check("rnd.we",     32'(bus_we),   e_we);
      check("rnd.addr",   32'(bus_addr), e_addr);
      check("rnd.dout",   bus_dout,      e_dout);
      check("rnd.m0_ack", 32'(m0_ack),   e_a0);
      check("rnd.m1_ack", 32'(m1_ack),   e_a1);
      check("rnd.m0_din", m0_din,        e_d0);
      check("rnd.m1_din", m1_din,        e_d1);
      if (owner < 0) begin
        stall = 0;
        if (req[0] && req[1]) owner = 1 - last;
        else if (req[0])      owner = 0;
        else if (req[1])      owner = 1;
      end else if (ack) begin
        req[owner] = 0;
        last  = owner;
        owner = -1;
      end else begin
        stall++;
      end
      tick();
    end
    clear_inputs();

`ifdef BUS_ARB_TIMEOUT_EN
    // Ack exactly at the limit (8th grant cycle) is a normal completion
    do_reset();
    m0_stb = 1; m0_addr = 22'h000200;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) begin bus_ack = 1; bus_din = 32'hA5A5A5A5; end
      #1;
      check($sformatf("lim.c%0d.m0_ack", c), 32'(m0_ack), (c == 8) ? 1 : 0);
    end
    check("lim.m0_din", m0_din, 32'hA5A5A5A5);
    check("lim.bus_stb", 32'(bus_stb), 1);
    tick();
    clear_inputs();
    #1;
    check("lim.tmo_err", 32'(tmo_err), 0);

    // Silent slave: forced ack with zero data in the 8th grant cycle
    tick();
    m0_stb = 1; bus_din = 32'hFFFFFFFF;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("tmo.c%0d.m0_ack", c), 32'(m0_ack), (c == 8) ? 1 : 0);
    end
    check("tmo.m0_din", m0_din, 0);
    check("tmo.bus_stb", 32'(bus_stb), 0);
    check("tmo.gnt", 32'(gnt), 1);
    tick();
    m0_stb = 0;
    #1;
    check("tmo.idle", 32'(gnt), 0);
    check("tmo.err_set", 32'(tmo_err), 1);
    for (int c = 0; c < 5; c++) tick();
    check("tmo.err_sticky", 32'(tmo_err), 1);
    do_reset();
    check("tmo.err_clr", 32'(tmo_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case a wait above never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_bus_arb time limit");
  end

endmodule
